// File: rtl/nibble_add_seq.sv
// Wide add/subtract sequencer: drives a shared 4-bit combinational adder one
// nibble per clock (LSB first), holding the ripple carry in a register.
module nibble_add_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  input  logic         carry_in,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         busy
);

  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           res_cout_q, res_cout_d;
  logic           res_ovf_q, res_ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      res_cout_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      res_cout_q <= res_cout_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    res_cout_d = res_cout_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          // Subtraction is A + ~B + 1, so B is stored inverted and the carry seeded.
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub ? 1'b1 : carry_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = add_sum;
        carry_d                = add_cout;
        idx_d                  = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES - 1)) begin
          res_cout_d = add_cout;
          res_ovf_d  = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      // Gated by rst so the request side sees not-ready throughout reset.
      IDLE: start_ready = ~rst;
      RUN: begin
        add_a   = a_q[4*idx_q +: 4];
        add_b   = b_q[4*idx_q +: 4];
        add_cin = carry_q;
      end
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign result   = result_q;
  assign res_cout = res_cout_q;
  assign res_ovf  = res_ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: 16-bit and 8-bit builds, each wired to a
// behavioural 4-bit adder.
module tb_nibble_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // 16-bit instance
  logic        start_valid = 1'b0, start_ready;
  logic [15:0] op_a = '0, op_b = '0;
  logic        op_sub = 1'b0, carry_in = 1'b0;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] result;
  logic        res_cout, res_ovf, busy;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .carry_in(carry_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_cout(res_cout), .res_ovf(res_ovf), .busy(busy)
  );

  // 8-bit instance
  logic       n2_start_valid = 1'b0, n2_start_ready;
  logic [7:0] n2_op_a = '0, n2_op_b = '0;
  logic       n2_op_sub = 1'b0, n2_carry_in = 1'b0;
  logic [3:0] n2_add_a, n2_add_b, n2_add_sum;
  logic       n2_add_cin, n2_add_cout;
  logic       n2_res_valid, n2_res_ready = 1'b0;
  logic [7:0] n2_result;
  logic       n2_res_cout, n2_res_ovf, n2_busy;

  assign {n2_add_cout, n2_add_sum} = {1'b0, n2_add_a} + {1'b0, n2_add_b} + {4'b0, n2_add_cin};

  nibble_add_seq #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .start_valid(n2_start_valid), .start_ready(n2_start_ready),
    .op_a(n2_op_a), .op_b(n2_op_b), .op_sub(n2_op_sub), .carry_in(n2_carry_in),
    .add_a(n2_add_a), .add_b(n2_add_b), .add_cin(n2_add_cin),
    .add_sum(n2_add_sum), .add_cout(n2_add_cout),
    .res_valid(n2_res_valid), .res_ready(n2_res_ready),
    .result(n2_result), .res_cout(n2_res_cout), .res_ovf(n2_res_ovf), .busy(n2_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
    int n = 0;
    while (!start_ready && n < 20) begin
      step();
      n++;
    end
    chk("start_ready_wait", 32'(start_ready), 32'd1);
    op_a = a; op_b = b; op_sub = sub; carry_in = cin;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input logic scramble,
                        input logic [15:0] e_res, input logic e_cout, input logic e_ovf);
    int lat = 0;
    start_op(a, b, sub, cin);
    while (!res_valid && lat < 20) begin
      if (scramble) begin
        op_a = 16'($urandom); op_b = 16'($urandom);
        op_sub = 1'($urandom); carry_in = 1'($urandom);
      end
      step();
      lat++;
    end
    $display("op %s: a=%h b=%h sub=%0d cin=%0d -> result=%h cout=%0d ovf=%0d lat=%0d",
             tag, a, b, sub, cin, result, res_cout, res_ovf, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_result"}, 32'(result), 32'(e_res));
    chk({tag, "_cout"}, 32'(res_cout), 32'(e_cout));
    chk({tag, "_ovf"}, 32'(res_ovf), 32'(e_ovf));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t[$];
    int lat;
    #1 rst = 1'b1;
    #2;
    chk("reset_start_ready", 32'(start_ready), 32'd0);
    chk("reset_outputs", 32'({busy, res_valid, add_a, add_b, add_cin, res_cout, res_ovf}), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_reset_start_ready", 32'(start_ready), 32'd1);

    // 0x1234 + 0x0FCD: watch the nibble stream to the adder
    start_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    chk("seq_busy", 32'(busy), 32'd1);
    chk("seq_start_ready", 32'(start_ready), 32'd0);
    chk("seq_n0", 32'({add_a, add_b, add_cin}), 32'({4'h4, 4'hD, 1'b0}));
    step();
    chk("seq_n1", 32'({add_a, add_b, add_cin}), 32'({4'h3, 4'hC, 1'b1}));
    step();
    chk("seq_n2", 32'({add_a, add_b, add_cin}), 32'({4'h2, 4'hF, 1'b1}));
    step();
    chk("seq_n3", 32'({add_a, add_b, add_cin}), 32'({4'h1, 4'h0, 1'b1}));
    chk("seq_not_valid_yet", 32'(res_valid), 32'd0);
    step();
    $display("op seq: a=1234 b=0fcd -> result=%h cout=%0d ovf=%0d", result, res_cout, res_ovf);
    chk("seq_valid", 32'(res_valid), 32'd1);
    chk("seq_result", 32'(result), 32'h2201);
    chk("seq_flags", 32'({res_cout, res_ovf}), 32'd0);
    chk("seq_adder_idle", 32'({add_a, add_b, add_cin}), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("seq_handoff_ready", 32'(start_ready), 32'd1);
    chk("seq_handoff_valid", 32'(res_valid), 32'd0);

    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("scramble", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);

    // Backpressure: hold DONE for 10 cycles, with an ignored start pulse
    start_op(16'h0101, 16'h0202, 1'b0, 1'b0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      step();
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        op_a = 16'hFFFF; op_b = 16'hFFFF; start_valid = 1'b1;
      end
      step();
      start_valid = 1'b0;
      chk("bp_result", 32'(result), 32'h0303);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      chk("bp_valid", 32'(res_valid), 32'd1);
    end
    $display("op backpressure: result=%h held 10 cycles", result);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_release_ready", 32'(start_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);

    // Back-to-back: completions every NIBBLES+2 cycles
    op_a = 16'h0010; op_b = 16'h0020; op_sub = 1'b0; carry_in = 1'b0;
    start_valid = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) begin
        t.push_back(c);
        chk("b2b_result", 32'(result), 32'h0030);
        $display("op b2b: completion at cycle %0d result=%h", c, result);
      end
      step();
    end
    start_valid = 1'b0;
    lat = 0;
    while (busy && lat < 20) begin
      step();
      lat++;
    end
    res_ready = 1'b0;
    chk("b2b_count", 32'(t.size()), 32'd3);
    if (t.size() >= 3) begin
      chk("b2b_gap0", 32'(t[1] - t[0]), 32'd6);
      chk("b2b_gap1", 32'(t[2] - t[1]), 32'd6);
    end

    // Asynchronous reset after two nibbles of 0x1234 + 0x1111
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    $display("op abort: outputs after async rst busy=%0d valid=%0d result=%h", busy, res_valid, result);
    chk("abort_outputs", 32'({start_ready, busy, res_valid, add_a, add_b, add_cin, res_cout, res_ovf}), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    step();
    rst = 1'b0;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // 8-bit build: 0xFF + 0x01
    n2_op_a = 8'hFF; n2_op_b = 8'h01; n2_op_sub = 1'b0; n2_carry_in = 1'b0;
    chk("n2_ready", 32'(n2_start_ready), 32'd1);
    n2_start_valid = 1'b1;
    step();
    n2_start_valid = 1'b0;
    lat = 0;
    while (!n2_res_valid && lat < 20) begin
      step();
      lat++;
    end
    $display("op n2: a=ff b=01 -> result=%h cout=%0d lat=%0d", n2_result, n2_res_cout, lat);
    chk("n2_latency", 32'(lat), 32'd2);
    chk("n2_result", 32'(n2_result), 32'h00);
    chk("n2_cout", 32'(n2_res_cout), 32'd1);
    n2_res_ready = 1'b1;
    step();
    n2_res_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-cycle controller that sequences the team's combinational 4-bit adder (ports a, b, cin, sum, cout) to perform wide add/subtract, one nibble per clock, LSB nibble first, with ripple carry held in a register.
- Sits between the processor's ALU issue logic (valid/ready request) and a single shared adder_4bit instance, which it drives through its add_* ports.

Parameters:
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 2..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start_valid  in  1  request valid
- start_ready  out  1  controller can accept a request
- op_a  in  W  operand A
- op_b  in  W  operand B
- op_sub  in  1  1 = A-B, 0 = A+B+carry_in
- carry_in  in  1  carry into nibble 0 for add; ignored when op_sub=1
- add_a  out  4  to adder input a
- add_b  out  4  to adder input b
- add_cin  out  1  to adder input cin
- add_sum  in  4  from adder sum (combinational, same cycle)
- add_cout  in  1  from adder cout
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- result  out  W  sum/difference
- res_cout  out  1  final carry out (sub: 1 = no borrow)
- res_ovf  out  1  two's-complement overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst high): state IDLE, idx 0, carry 0, operand/result regs 0. All outputs 0, including start_ready, while rst is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready at an edge: latch a_reg=op_a and b_reg=(op_sub ? ~op_b : op_b).
  - Set carry=(op_sub ? 1 : carry_in) and idx=0, then go to RUN.
- RUN:
  - start_ready=0.
  - add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
  - Each edge: result[4*idx+:4]<=add_sum, carry<=add_cout, idx<=idx+1.
  - On the edge with idx==NIBBLES-1:
    - res_cout<=add_cout.
    - res_ovf<=(a_reg[W-1]==b_reg[W-1]) && (add_sum[3]!=a_reg[W-1]).
    - Go to DONE.
- DONE:
  - res_valid=1. result/res_cout/res_ovf held stable until the res_valid & res_ready edge, then go to IDLE.
  - start_ready reasserts the cycle after the handoff; there is no same-cycle accept.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- Latency: accept at edge E0 gives res_valid high after edge E0+NIBBLES. Minimum issue interval is NIBBLES+2 cycles.
- Inputs: op_a, op_b, op_sub and carry_in are sampled only at the accept edge. Changes afterwards, and start_valid during RUN/DONE, are ignored.
- result is W bits. Carry beyond bit W-1 appears only in res_cout. No wrap or saturation beyond modulo 2^W.
- A result not yet accepted is held indefinitely; there is no timeout.
- rst asserted mid-RUN or in DONE aborts the operation immediately: all outputs go to 0 and the partial result is discarded. First request after rst deasserts is accepted normally.

Test Plan:
- Add 0x1234 + 0x0FCD, carry_in=0:
  - add_a sequence 4,3,2,1 on consecutive cycles.
  - result=0x2201, res_cout=0, res_ovf=0.
  - res_valid high 4 edges after accept.
- Add 0xFFFF + 0x0001, carry_in=0 -> result=0x0000, res_cout=1, res_ovf=0. Add 0x7FFF + 0x0000, carry_in=1 -> result=0x8000, res_cout=0, res_ovf=1.
- Subtract:
  - 0x0005 - 0x0007 -> result=0xFFFE, res_cout=0, res_ovf=0.
  - 0x8000 - 0x0001 -> result=0x7FFF, res_cout=1, res_ovf=1.
  - carry_in=1 ignored in both.
- Backpressure:
  - Hold res_ready=0 for 10 cycles in DONE. result stays stable, start_ready stays 0, and a start_valid pulse is not accepted.
  - Release res_ready: start_ready=1 on the following cycle. Back-to-back requests complete every 6 cycles.
- Change op_a/op_b/op_sub every cycle during RUN -> result matches the values latched at accept.
- Assert rst asynchronously (mid-cycle) after 2 nibbles of 0x1234+0x1111:
  - All outputs drop to 0 immediately, with no res_valid.
  - After release, 0x0001+0x0001 gives 0x0002.
- NIBBLES=2 build: 0xFF + 0x01 -> result=0x00, res_cout=1, latency 2 edges.
